// File: rtl/irq_pc_sequencer.sv
// Next-PC arbiter with prioritised interrupt entry: drains the pipeline, vectors
// to the per-line handler, and returns to the saved PC on MRET.
module irq_pc_sequencer #(
  parameter int CORE          = 0,
  parameter int ADDRESS_BITS  = 20,
  parameter int N_IRQ         = 4,
  parameter int ID_BITS       = (N_IRQ > 1) ? $clog2(N_IRQ) : 1,
  parameter int VECTOR_BASE   = 'hc0,
  parameter int VECTOR_STRIDE = 4,
  parameter int DRAIN_CYCLES  = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [6:0]              opcode_decode,
  input  logic [6:0]              opcode_execute,
  input  logic [ADDRESS_BITS-1:0] JALR_target_execute,
  input  logic [ADDRESS_BITS-1:0] branch_target_execute,
  input  logic [ADDRESS_BITS-1:0] JAL_target_decode,
  input  logic                    branch_execute,
  input  logic [ADDRESS_BITS-1:0] PC_fetch,
  input  logic                    JALR_branch_hazard,
  input  logic                    true_data_hazard,
  input  logic                    JAL_hazard,
  input  logic                    i_mem_hazard,
  input  logic                    d_mem_issue_hazard,
  input  logic                    d_mem_recv_hazard,
  input  logic [N_IRQ-1:0]        irq,
  input  logic                    irq_enable,
  input  logic                    mret_decode,
  output logic [1:0]              next_PC_sel,
  output logic [ADDRESS_BITS-1:0] target_PC,
  output logic [N_IRQ-1:0]        irq_ack,
  output logic                    in_interrupt,
  output logic [ID_BITS-1:0]      active_irq_id,
  input  logic                    scan
);

  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_JUMP,
    S_SERVICE,
    S_RETURN
  } state_t;

  state_t                  state, state_next;
  logic [ADDRESS_BITS-1:0] saved_pc, saved_pc_next;
  logic [3:0]              drain_cnt, drain_cnt_next;
  logic [ID_BITS-1:0]      irq_id_next, lowest_id;
  logic                    in_int_next;
  logic [ADDRESS_BITS-1:0] normal_target, vector_target;
  logic [1:0]              normal_sel;
  logic                    irq_start;

  // The trace hook has no synthesizable behaviour; keep it visibly consumed.
  logic unused_scan;
  assign unused_scan = scan ^ (CORE != 0);

  always_comb begin
    normal_sel = 2'b00;
    if (JALR_branch_hazard)     normal_sel = 2'b10;
    else if (true_data_hazard)  normal_sel = 2'b01;
    else if (JAL_hazard)        normal_sel = 2'b10;
    else if (i_mem_hazard || d_mem_issue_hazard || d_mem_recv_hazard)
                                normal_sel = 2'b01;
  end

  always_comb begin
    normal_target = '0;
    if (opcode_execute == OP_JALR)
      normal_target = JALR_target_execute;
    else if (opcode_execute == OP_BRANCH && branch_execute)
      normal_target = branch_target_execute;
    else if (opcode_decode == OP_JAL)
      normal_target = JAL_target_decode;
  end

  always_comb begin
    lowest_id = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (irq[i]) lowest_id = ID_BITS'(i);
    end
  end

  assign vector_target = ADDRESS_BITS'(VECTOR_BASE + int'(active_irq_id) * VECTOR_STRIDE);

  // A control-flow redirect in the same cycle wins; entry retries next cycle.
  assign irq_start = irq_enable && (|irq) && !JAL_hazard && !JALR_branch_hazard;

  always_comb begin
    state_next     = state;
    saved_pc_next  = saved_pc;
    drain_cnt_next = drain_cnt;
    irq_id_next    = active_irq_id;
    in_int_next    = in_interrupt;
    next_PC_sel    = normal_sel;
    target_PC      = normal_target;
    irq_ack        = '0;
    unique case (state)
      S_IDLE: begin
        if (irq_start) begin
          state_next     = S_DRAIN;
          irq_id_next    = lowest_id;
          saved_pc_next  = PC_fetch;
          drain_cnt_next = 4'(DRAIN_CYCLES - 1);
        end
      end
      S_DRAIN: begin
        // An in-flight JALR/branch still redirects, and the handler must
        // return to that target instead of the originally fetched PC.
        if (JALR_branch_hazard) begin
          next_PC_sel   = 2'b10;
          saved_pc_next = normal_target;
        end else begin
          next_PC_sel = 2'b01;
        end
        if (drain_cnt == 4'd0) state_next = S_JUMP;
        else                   drain_cnt_next = drain_cnt - 4'd1;
      end
      S_JUMP: begin
        next_PC_sel = 2'b10;
        target_PC   = vector_target;
        irq_ack     = N_IRQ'(1) << active_irq_id;
        in_int_next = 1'b1;
        state_next  = S_SERVICE;
      end
      S_SERVICE: begin
        if (mret_decode) state_next = S_RETURN;
      end
      S_RETURN: begin
        next_PC_sel = 2'b10;
        target_PC   = saved_pc;
        in_int_next = 1'b0;
        state_next  = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_IDLE;
      saved_pc      <= '0;
      drain_cnt     <= '0;
      active_irq_id <= '0;
      in_interrupt  <= 1'b0;
    end else begin
      state         <= state_next;
      saved_pc      <= saved_pc_next;
      drain_cnt     <= drain_cnt_next;
      active_irq_id <= irq_id_next;
      in_interrupt  <= in_int_next;
    end
  end

endmodule

// File: tb/tb_irq_pc_sequencer.sv
// Directed bench for irq_pc_sequencer: the driver queues the expected outputs
// for each cycle, a negedge monitor pops and compares them.
module tb_irq_pc_sequencer;

  localparam int W = 29;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic        clock;
  logic        reset;
  logic [6:0]  opcode_decode, opcode_execute;
  logic [19:0] JALR_target_execute, branch_target_execute, JAL_target_decode;
  logic        branch_execute;
  logic [19:0] PC_fetch;
  logic        JALR_branch_hazard, true_data_hazard, JAL_hazard;
  logic        i_mem_hazard, d_mem_issue_hazard, d_mem_recv_hazard;
  logic [3:0]  irq;
  logic        irq_enable, mret_decode, scan;
  logic [1:0]  next_PC_sel;
  logic [19:0] target_PC;
  logic [3:0]  irq_ack;
  logic        in_interrupt;
  logic [1:0]  active_irq_id;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           total = 0;
  int           bad = 0;

  irq_pc_sequencer dut (
    .clock(clock), .reset(reset),
    .opcode_decode(opcode_decode), .opcode_execute(opcode_execute),
    .JALR_target_execute(JALR_target_execute),
    .branch_target_execute(branch_target_execute),
    .JAL_target_decode(JAL_target_decode),
    .branch_execute(branch_execute), .PC_fetch(PC_fetch),
    .JALR_branch_hazard(JALR_branch_hazard), .true_data_hazard(true_data_hazard),
    .JAL_hazard(JAL_hazard), .i_mem_hazard(i_mem_hazard),
    .d_mem_issue_hazard(d_mem_issue_hazard), .d_mem_recv_hazard(d_mem_recv_hazard),
    .irq(irq), .irq_enable(irq_enable), .mret_decode(mret_decode),
    .next_PC_sel(next_PC_sel), .target_PC(target_PC), .irq_ack(irq_ack),
    .in_interrupt(in_interrupt), .active_irq_id(active_irq_id), .scan(scan)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no end, want end of stimulus");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic cyc(input string nm, input logic [1:0] sel, input logic [19:0] tgt,
                     input logic [3:0] ack, input logic inint, input logic [1:0] id);
    exp_q.push_back({sel, tgt, ack, inint, id});
    name_q.push_back(nm);
    tick();
  endtask

  task automatic clear_inputs;
    opcode_decode = '0; opcode_execute = '0;
    JALR_target_execute = '0; branch_target_execute = '0; JAL_target_decode = '0;
    branch_execute = 0; PC_fetch = '0;
    JALR_branch_hazard = 0; true_data_hazard = 0; JAL_hazard = 0;
    i_mem_hazard = 0; d_mem_issue_hazard = 0; d_mem_recv_hazard = 0;
    irq = '0; irq_enable = 0; mret_decode = 0; scan = 0;
  endtask

  // scoreboard monitor
  initial begin
    logic [W-1:0] e, a;
    string nm;
    forever begin
      @(negedge clock);
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = {next_PC_sel, target_PC, irq_ack, in_interrupt, active_irq_id};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL %s: got sel=%b tgt=%h ack=%b int=%b id=%0d, want sel=%b tgt=%h ack=%b int=%b id=%0d",
                   nm, a[28:27], a[26:7], a[6:3], a[2], a[1:0],
                   e[28:27], e[26:7], e[6:3], e[2], e[1:0]);
        end
      end
    end
  end

  // stimulus
  initial begin
    clear_inputs();
    reset = 1;
    tick(); tick();
    cyc("reset_state", 2'b00, 20'h0, 4'b0000, 0, 2'd0);
    reset = 0;

    // Entry on line 2, drain of 3, vector 0xc8, MRET back to 0x200
    irq_enable = 1; irq = 4'b0100; PC_fetch = 20'h200;
    cyc("a_idle",      2'b00, 20'h0,   4'b0000, 0, 2'd0);
    cyc("a_drain1",    2'b01, 20'h0,   4'b0000, 0, 2'd2);
    irq = 4'b0000;
    cyc("a_drain2",    2'b01, 20'h0,   4'b0000, 0, 2'd2);
    cyc("a_drain3",    2'b01, 20'h0,   4'b0000, 0, 2'd2);
    cyc("a_jump",      2'b10, 20'h0c8, 4'b0100, 0, 2'd2);
    irq = 4'b0001;
    cyc("a_svc",       2'b00, 20'h0,   4'b0000, 1, 2'd2);
    true_data_hazard = 1;
    cyc("a_svc_hz",    2'b01, 20'h0,   4'b0000, 1, 2'd2);
    true_data_hazard = 0; mret_decode = 1;
    cyc("a_svc_mret",  2'b00, 20'h0,   4'b0000, 1, 2'd2);
    mret_decode = 0; irq = 4'b0000;
    cyc("a_return",    2'b10, 20'h200, 4'b0000, 1, 2'd2);
    cyc("a_idle_back", 2'b00, 20'h0,   4'b0000, 0, 2'd2);

    // Lines 1 and 3 together; JALR redirect in 2nd drain cycle moves saved PC
    PC_fetch = 20'h300; irq = 4'b1010;
    cyc("b_idle",       2'b00, 20'h0,   4'b0000, 0, 2'd2);
    cyc("b_drain1",     2'b01, 20'h0,   4'b0000, 0, 2'd1);
    JALR_branch_hazard = 1; opcode_execute = OP_JALR; JALR_target_execute = 20'h340;
    cyc("b_drain_jalr", 2'b10, 20'h340, 4'b0000, 0, 2'd1);
    JALR_branch_hazard = 0; opcode_execute = '0;
    cyc("b_drain3",     2'b01, 20'h0,   4'b0000, 0, 2'd1);
    cyc("b_jump",       2'b10, 20'h0c4, 4'b0010, 0, 2'd1);
    mret_decode = 1;
    cyc("b_svc_mret",   2'b00, 20'h0,   4'b0000, 1, 2'd1);
    mret_decode = 0; irq = 4'b1000; PC_fetch = 20'h400;
    cyc("b_return",     2'b10, 20'h340, 4'b0000, 1, 2'd1);
    cyc("b3_idle",      2'b00, 20'h0,   4'b0000, 0, 2'd1);
    irq = 4'b0000;
    cyc("b3_drain1",    2'b01, 20'h0,   4'b0000, 0, 2'd3);
    cyc("b3_drain2",    2'b01, 20'h0,   4'b0000, 0, 2'd3);
    cyc("b3_drain3",    2'b01, 20'h0,   4'b0000, 0, 2'd3);
    cyc("b3_jump",      2'b10, 20'h0cc, 4'b1000, 0, 2'd3);
    mret_decode = 1;
    cyc("b3_svc_mret",  2'b00, 20'h0,   4'b0000, 1, 2'd3);
    mret_decode = 0;
    cyc("b3_return",    2'b10, 20'h400, 4'b0000, 1, 2'd3);
    cyc("b3_idle_back", 2'b00, 20'h0,   4'b0000, 0, 2'd3);

    // Interrupts disabled: pure arbitration, target mux, stray MRET
    irq_enable = 0; irq = 4'b0001;
    true_data_hazard = 1; JAL_hazard = 1; opcode_decode = OP_JAL; JAL_target_decode = 20'h123;
    cyc("c_tdh_jal",    2'b01, 20'h123, 4'b0000, 0, 2'd3);
    true_data_hazard = 0;
    cyc("c_jal",        2'b10, 20'h123, 4'b0000, 0, 2'd3);
    JAL_hazard = 0; JALR_branch_hazard = 1; true_data_hazard = 1;
    opcode_execute = OP_BRANCH; branch_execute = 1; branch_target_execute = 20'h456;
    cyc("c_jalr_tdh",   2'b10, 20'h456, 4'b0000, 0, 2'd3);
    JALR_branch_hazard = 0; true_data_hazard = 0; branch_execute = 0;
    cyc("c_br_nt",      2'b00, 20'h123, 4'b0000, 0, 2'd3);
    opcode_execute = OP_JALR; JALR_target_execute = 20'h340;
    cyc("c_tgt_jalr",   2'b00, 20'h340, 4'b0000, 0, 2'd3);
    opcode_execute = '0; opcode_decode = '0; i_mem_hazard = 1;
    cyc("c_imem",       2'b01, 20'h0,   4'b0000, 0, 2'd3);
    i_mem_hazard = 0; d_mem_issue_hazard = 1;
    cyc("c_dmem_issue", 2'b01, 20'h0,   4'b0000, 0, 2'd3);
    d_mem_issue_hazard = 0; d_mem_recv_hazard = 1;
    cyc("c_dmem_recv",  2'b01, 20'h0,   4'b0000, 0, 2'd3);
    d_mem_recv_hazard = 0; mret_decode = 1;
    cyc("c_mret_idle",  2'b00, 20'h0,   4'b0000, 0, 2'd3);
    mret_decode = 0;
    cyc("c_after_mret", 2'b00, 20'h0,   4'b0000, 0, 2'd3);

    // Entry deferred by a JAL redirect, then reset in the middle of the drain
    irq_enable = 1; irq = 4'b0001; PC_fetch = 20'h600;
    JAL_hazard = 1; opcode_decode = OP_JAL; JAL_target_decode = 20'h500;
    cyc("d_defer",      2'b10, 20'h500, 4'b0000, 0, 2'd3);
    JAL_hazard = 0; opcode_decode = '0;
    cyc("d_idle",       2'b00, 20'h0,   4'b0000, 0, 2'd3);
    cyc("d_drain1",     2'b01, 20'h0,   4'b0000, 0, 2'd0);
    irq = 4'b0000; reset = 1;
    cyc("d_drain_rst",  2'b01, 20'h0,   4'b0000, 0, 2'd0);
    cyc("d_rst_idle",   2'b00, 20'h0,   4'b0000, 0, 2'd0);
    reset = 0;
    cyc("d_post1",      2'b00, 20'h0,   4'b0000, 0, 2'd0);
    cyc("d_post2",      2'b00, 20'h0,   4'b0000, 0, 2'd0);
    cyc("d_post3",      2'b00, 20'h0,   4'b0000, 0, 2'd0);

    // final report
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clock);
    #1;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_queue: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
